// File: rtl/bfnp_branch_resolve_update.sv
// Branch resolution side of the neural predictor: in-order prediction queue,
// predictor update bundle, misprediction flush and branch statistics.
module bfnp_branch_resolve_update #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  input  logic             pred_taken,
  input  logic [31:0]      pred_npc,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic [31:0]      res_inst,
  output logic             Branch_direction,
  output logic [31:0]      PC_actual,
  output logic [31:0]      PC_alu,
  output logic [31:0]      inst,
  output logic             update_valid,
  output logic             rst_pipeline,
  output logic [PTR_W:0]   occupancy,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  typedef enum logic {NORMAL, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] npc;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t           state;
  entry_t           mem [DEPTH];
  entry_t           in_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;
  logic             uv_q;
  logic             rp_q;
  logic             active;
  logic             empty;
  logic             full;
  logic             push_ok;
  logic             pop_ok;
  logic             mispred;
  logic             flush_go;
  logic [31:0]      npc_act;

  always_comb begin
    in_ent   = '{pc: pred_pc, taken: pred_taken, npc: pred_npc};
    active   = !stall && (state == NORMAL);
    empty    = (occ == '0);
    full     = (occ == FULL);
    // An empty queue can still retire through the same-cycle push.
    pop_ok   = active && res_valid && (!empty || pred_valid);
    push_ok  = active && pred_valid && (!full || res_valid);
    head     = empty ? in_ent : mem[rd_ptr];
    npc_act  = res_taken ? res_target : head.pc + 32'd4;
    mispred  = (head.taken != res_taken) || (npc_act != head.npc);
    flush_go = pop_ok && mispred;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_go)
      mem[wr_ptr] <= in_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= NORMAL;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      uv_q             <= 1'b0;
      rp_q             <= 1'b0;
      Branch_direction <= 1'b0;
      PC_actual        <= '0;
      PC_alu           <= '0;
      inst             <= '0;
      overflow_err     <= 1'b0;
      underflow_err    <= 1'b0;
      branch_cnt       <= '0;
      mispred_cnt      <= '0;
    end else begin
      if (!stall) begin
        uv_q <= pop_ok;
        rp_q <= flush_go;
      end
      if (pop_ok) begin
        Branch_direction <= res_taken;
        PC_actual        <= npc_act;
        PC_alu           <= res_target;
        inst             <= res_inst;
        if (branch_cnt != '1)
          branch_cnt <= branch_cnt + 32'd1;
        if (mispred && mispred_cnt != '1)
          mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (active && pred_valid && !push_ok)
        overflow_err <= 1'b1;
      if (active && res_valid && !pop_ok)
        underflow_err <= 1'b1;
      unique case (state)
        NORMAL: if (flush_go) state <= FLUSH;
        FLUSH:  if (!stall) state <= NORMAL;
        default: state <= NORMAL;
      endcase
      if (flush_go) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({push_ok, pop_ok})
          2'b10:   occ <= occ + (PTR_W+1)'(1);
          2'b01:   occ <= occ - (PTR_W+1)'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  // Strobes are suppressed while stalled; the held register re-presents
  // a pending strobe once the stall releases.
  assign update_valid = uv_q & ~stall;
  assign rst_pipeline = rp_q & ~stall;
  assign occupancy    = occ;

endmodule
